// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the data-memory responder slice
//               (access sizes, responder FSM states, default depth).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Default array depth in 32-bit words
  localparam int DEPTH_WORDS_DFLT = 254;

  // Access size encodings; 2'b11 is illegal
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Responder state machine
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_lane_fmt
// Description : Combinational little-endian lane handling. Replicates store
//               data into lanes with byte enables, and extracts plus sign/zero
//               extends load data from a full memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wword,
  output logic [3:0]  o_be,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select lanes for both directions from size and low address bits
  always_comb begin
    o_wword = '0;
    o_be    = '0;
    o_rdata = '0;
    w_byte  = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    case (i_size)
      SIZE_B: begin
        o_wword = {4{i_wdata[7:0]}};
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SIZE_H: begin
        o_wword = {2{i_wdata[15:0]}};
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_rdata = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SIZE_W: begin
        o_wword = i_wdata;
        o_be    = 4'b1111;
        o_rdata = i_rword;
      end
      default: begin
        o_wword = '0;
        o_be    = '0;
        o_rdata = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : MEM-stage data-memory responder. Clears the array after reset,
//               then serves one load/store per two cycles over valid/ready
//               with a one-cycle response strobe, plus a low-priority debug
//               word-read port.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DFLT,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_error,
  input  logic              i_dbg_req,
  input  logic [7:0]        i_dbg_addr,
  output logic              o_dbg_valid,
  output logic [31:0]       o_dbg_data,
  output logic              o_busy
);

  // The debug port addresses at most 256 words, so DEPTH_WORDS <= 256
  localparam int                IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-3:0] C_DEPTH_A  = (ADDR_W-2)'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_clr_cnt;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [ADDR_W-3:0] w_word_idx;
  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_dbg_idx;
  logic              w_in_range;
  logic              w_misalign;
  logic              w_err;
  logic              w_hs;
  logic              w_dbg_fire;
  logic              w_dbg_in_range;
  logic [31:0]       w_rword;
  logic [31:0]       w_wword;
  logic [31:0]       w_ldata;
  logic [3:0]        w_be;

  assign w_word_idx     = i_req_addr[ADDR_W-1:2];
  assign w_req_idx      = w_word_idx[IDX_W-1:0];
  assign w_in_range     = (w_word_idx < C_DEPTH_A);
  assign w_misalign     = ((i_req_size == SIZE_H) && i_req_addr[0]) ||
                          ((i_req_size == SIZE_W) && (i_req_addr[1:0] != 2'b00));
  assign w_err          = (i_req_size == 2'b11) || w_misalign || !w_in_range;
  assign w_hs           = i_req_valid && (r_state == ST_IDLE);
  assign w_dbg_fire     = i_dbg_req && !i_req_valid && (r_state == ST_IDLE);
  assign w_dbg_idx      = i_dbg_addr[IDX_W-1:0];
  assign w_dbg_in_range = ({24'd0, i_dbg_addr} < 32'(DEPTH_WORDS));
  assign w_rword        = w_in_range ? r_mem[w_req_idx] : 32'd0;
  assign o_req_ready    = (r_state == ST_IDLE);

  data_mem_lane_fmt u_lane_fmt (
    .i_size     (i_req_size),
    .i_addr_lo  (i_req_addr[1:0]),
    .i_unsigned (i_req_unsigned),
    .i_wdata    (i_req_wdata),
    .i_rword    (w_rword),
    .o_wword    (w_wword),
    .o_be       (w_be),
    .o_rdata    (w_ldata)
  );

  // Array writes: zero fill while clearing, byte-enabled stores otherwise
  always_ff @(posedge i_clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= 32'd0;
    end else if (w_hs && i_req_write && !w_err) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) begin
          r_mem[w_req_idx][8*l +: 8] <= w_wword[8*l +: 8];
        end
      end
    end
  end

  // Control FSM with registered response, debug and busy outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_error <= 1'b0;
      o_dbg_valid <= 1'b0;
      o_dbg_data  <= '0;
      o_busy      <= 1'b1;
    end else begin
      o_rsp_valid <= 1'b0;
      o_dbg_valid <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == C_LAST_IDX) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_hs) begin
            r_state     <= ST_RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_error <= w_err;
            o_rsp_rdata <= (w_err || i_req_write) ? 32'd0 : w_ldata;
          end else if (w_dbg_fire) begin
            o_dbg_valid <= 1'b1;
            o_dbg_data  <= w_dbg_in_range ? r_mem[w_dbg_idx] : 32'd0;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface: accepts load/store requests over a valid/ready handshake and returns one response per request.
- Supports byte, halfword and word accesses with little-endian lanes and sign/zero extension, and flags misaligned or out-of-range accesses.
- After reset, a clear sequence zeroes the whole array before the first request is accepted.
- A low-priority debug word-read port lets the debug unit dump memory.

Parameters:
- DEPTH_WORDS, 254, number of 32-bit words (1016 bytes).
- ADDR_W, 32, byte-address width of i_req_addr.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  responder can accept a request this cycle.
- i_req_write  in  1  1=store, 0=load.
- i_req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- i_req_unsigned  in  1  zero-extend loads (lbu/lhu).
- i_req_addr  in  ADDR_W  byte address.
- i_req_wdata  in  32  store data, right-justified.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_error  out  1  misaligned, out of range, or size=11.
- i_dbg_req  in  1  debug word-read request.
- i_dbg_addr  in  8  word index.
- o_dbg_valid  out  1  debug data strobe.
- o_dbg_data  out  32  debug read word.
- o_busy  out  1  high while clearing.

Behaviour:
- Reset (i_reset=0, async): FSM=CLEAR, clear counter=0, all outputs 0, o_busy=1, o_req_ready=0.
- CLEAR:
  - Write 0 to word[counter], one word per cycle.
  - After word DEPTH_WORDS-1 is written, go to IDLE. Clear takes exactly DEPTH_WORDS cycles after reset release.
  - Requests and debug requests are ignored during CLEAR.
- IDLE: o_req_ready=1, o_busy=0.
  - Handshake occurs when i_req_valid && o_req_ready at a rising edge.
  - Request fields are sampled only at the handshake.
- Accepted request:
  - Error check: size=11; half with addr[0]!=0; word with addr[1:0]!=0; or addr>>2 >= DEPTH_WORDS.
  - On error, memory is not modified.
- Store:
  - Byte enables: lane addr[1:0] for byte; lanes {addr[1],0} and {addr[1],1} for half; all four lanes for word.
  - Write data is replicated into the selected lanes.
  - The write commits at the handshake edge.
- Load: word read at the handshake edge, lane-selected, then sign- or zero-extended per i_req_unsigned. Word loads ignore i_req_unsigned.
- Latency and response:
  - o_rsp_valid=1 exactly one cycle after the handshake, for one cycle; no response backpressure.
  - FSM goes IDLE->RESP on accept. RESP has o_req_ready=0 and returns to IDLE, giving at most one request per 2 cycles.
  - o_rsp_rdata and o_rsp_error hold their values until the next response.
- Debug port:
  - Served only in IDLE cycles with no handshake.
  - o_dbg_valid/o_dbg_data appear the next cycle.
  - An out-of-range i_dbg_addr returns 0 with o_dbg_valid=1.
  - A debug request that collides with a handshake or occurs outside IDLE is dropped; the requester retries.
- Reset mid-operation: any pending response is discarded (o_rsp_valid=0) and CLEAR restarts from word 0.
- Address arithmetic: the word index is addr[ADDR_W-1:2], compared unsigned against DEPTH_WORDS.

Decomposition:
- Shared package (mem_pkg) holds:
  - size encodings SIZE_B/SIZE_H/SIZE_W;
  - FSM state encodings ST_CLEAR/ST_IDLE/ST_RESP;
  - DEPTH_WORDS default.
- Natural sub-module: data_mem_lane_fmt, combinational. It performs store lane replication plus byte enables, and load extraction plus extension.

Test Plan:
- Release reset and hold i_req_valid=1 -> o_req_ready stays 0 for 254 cycles then rises. A debug read of word 253 returns 0x00000000.
- sw 0xDEADBEEF @0x10, then lw @0x10 -> o_rsp_rdata=0xDEADBEEF one cycle after accept. lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE.
- sh 0x8001 @0x22 over a word preset to 0x11223344, then lw @0x20 -> 0x80013344. lh @0x22 -> 0xFFFF8001; lhu @0x22 -> 0x00008001.
- lw @0x11, sh @0x21, and sw @0x3F8 (word 254) -> o_rsp_error=1 and o_rsp_rdata=0. A following debug read of word 4 still shows 0xDEADBEEF.
- Back-to-back i_req_valid -> accepts occur every 2 cycles. A debug request issued in the RESP cycle is dropped; re-issued in IDLE, it gets o_dbg_valid the next cycle.
- Assert i_reset low in RESP cycle after sw -> o_rsp_valid never pulses, o_busy=1 and CLEAR restarts. Afterwards a load of the stored address returns 0.
